// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies use one registered full-width multiplier in PREP.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_BUSY = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]        state_reg, state_next;
    logic [2:0]        op_reg, op_next;
    logic [XLEN-1:0]   a_reg, a_next;
    logic [XLEN-1:0]   b_reg, b_next;
    logic [XLEN-1:0]   addend_reg, addend_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              neg_reg, neg_next;
    logic [XLEN-1:0]   result_reg, result_next;

    // Operand decode (op follows M-extension funct3)
    logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_prep;
    logic            div_by_zero, overflow;
    logic [XLEN-1:0] mag_a, mag_b, special_result;

    assign is_div   = op_reg[2];
    assign a_signed = is_div ? ~op_reg[0] : (op_reg[1] ^ op_reg[0]);
    assign b_signed = is_div ? ~op_reg[0] : (op_reg[1:0] == 2'b01);
    assign a_neg    = a_signed & a_reg[XLEN-1];
    assign b_neg    = b_signed & b_reg[XLEN-1];
    assign mag_a    = a_neg ? -a_reg : a_reg;
    assign mag_b    = b_neg ? -b_reg : b_reg;
    assign neg_prep = (is_div & op_reg[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_by_zero    = is_div && (b_reg == '0);
    assign overflow       = is_div && !op_reg[0] && (a_reg == {1'b1, {(XLEN-1){1'b0}}}) && (b_reg == '1);
    assign special_result = div_by_zero ? (op_reg[1] ? a_reg : '1) : (op_reg[1] ? '0 : a_reg);

    // One iteration step; PREP feeds fresh magnitudes so it performs the first step itself
    logic [2*XLEN-1:0] step_in, step_out;
    logic [XLEN-1:0]   step_add, div_sub;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;

    always_comb begin
        if (state_reg == ST_PREP) begin
            step_in  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            step_add = is_div ? mag_b : mag_a;
        end else begin
            step_in  = acc_reg;
            step_add = addend_reg;
        end
        mul_sum   = {1'b0, step_in[2*XLEN-1:XLEN]} + (step_in[0] ? {1'b0, step_add} : '0);
        div_shift = {step_in[2*XLEN-1:XLEN], step_in[XLEN-1]};
        div_ge    = div_shift >= {1'b0, step_add};
        div_sub   = div_shift[XLEN-1:0] - step_add;
        if (!is_div)
            step_out = {mul_sum, step_in[XLEN-1:1]};
        else if (div_ge)
            step_out = {div_sub, step_in[XLEN-2:0], 1'b1};
        else
            step_out = {div_shift[XLEN-1:0], step_in[XLEN-2:0], 1'b0};
    end

    // Sign correction and result-half selection
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_sel, fix_result;

    always_comb begin
        prod_fixed = neg_reg ? -acc_reg : acc_reg;
        div_sel    = op_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
        if (is_div)
            fix_result = neg_reg ? -div_sel : div_sel;
        else if (op_reg[1:0] == 2'b00)
            fix_result = prod_fixed[XLEN-1:0];
        else
            fix_result = prod_fixed[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_FAST_MUL_EN
    // Low 2*XLEN bits of the extended product are exact for every signedness mix
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_result;

    assign fast_a      = {{XLEN{a_neg}}, a_reg};
    assign fast_b      = {{XLEN{b_neg}}, b_reg};
    assign fast_prod   = fast_a * fast_b;
    assign fast_result = (op_reg[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        addend_next = addend_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        neg_next    = neg_reg;
        result_next = result_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    op_next    = op;
                    a_next     = operand_a;
                    b_next     = operand_b;
                    state_next = ST_PREP;
                end
            end
            ST_PREP: begin
                if (div_by_zero || overflow) begin
                    result_next = special_result;
                    state_next  = ST_DONE;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!is_div) begin
                    result_next = fast_result;
                    state_next  = ST_DONE;
                end
`endif
                else begin
                    acc_next    = step_out;
                    addend_next = step_add;
                    neg_next    = neg_prep;
                    cnt_next    = CW'(XLEN - 1);
                    state_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_next = step_out;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1))
                    state_next = ST_FIX;
            end
            ST_FIX: begin
                result_next = fix_result;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush)
            state_next = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            addend_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            addend_reg <= addend_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            neg_reg    <= neg_next;
            result_reg <= result_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32): results, latency, handshake, flush and reset.
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b, result;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 2;

    muldiv_unit #(.XLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Called #1 after the accept edge; counts cycles until out_valid (bounded)
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        int guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        op        = 3'b000;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0BAD_F00D;
        wait_out(lat);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(o, a, b, lat);
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        ack();
    endtask

    initial begin
        int lat;
        bit seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        run("MUL 7*-3",      MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run("MULH min*min",  MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run("MULHSU -1*max", MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run("MULHU max*max", MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run("MULH -3*5",     MULH,   32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, MUL_LAT);
        run("DIV -7/2",      DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run("REM -7%2",      REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run("DIVU",          DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, DIV_LAT);
        run("REMU",          REMU,   32'hFFFF_FFF9,  32'd2,         32'd1,         DIV_LAT);
        run("DIV 7/-2",      DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run("REM 7%-2",      REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LAT);
        run("DIV 5/0",       DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, SPC_LAT);
        run("REMU 5/0",      REMU,   32'd5,          32'd0,         32'd5,         SPC_LAT);
        run("DIV ovf",       DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        run("REM ovf",       REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SPC_LAT);

        // Back-pressure in DONE, then a request presented during the out handshake
        issue(DIVU, 32'd100, 32'd7, lat);
        check("DIVU 100/7 result", result, 32'd14);
        check("DIVU 100/7 latency", 32'(lat), 32'd34);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold result", result, 32'd14);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = DIVU;
        operand_a = 32'd100;
        operand_b = 32'd9;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("post-ack in_ready", 32'(in_ready), 32'd1);
        check("post-ack out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        check("DIVU 100/9 result", result, 32'd11);
        check("DIVU 100/9 latency", 32'(lat), 32'd34);
        ack();

        // Flush five cycles into a DIV
        @(negedge clock);
        in_valid = 1'b1; op = DIV; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush result kept", result, 32'd11);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush no out_valid", 32'(seen), 32'd0);
        run("MUL 3*4", MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

        // Reset while BUSY
        @(negedge clock);
        in_valid = 1'b1; op = DIVU; operand_a = 32'h1234_5678; operand_b = 32'd3;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst result", result, 32'd0);
        run("REMU 100%7", REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
